// File: rtl/avst_to_avmm_burst_master_pkg.sv
// Shared widths, command layout and width helper for the AVMM-to-AVST burst command bridge.
package avst_avmm_pkg;

  localparam int DEF_ADDR_WIDTH        = 48;
  localparam int DEF_DATA_WIDTH        = 512;
  localparam int DEF_BURST_WIDTH       = 3;
  localparam int DEF_MAX_PENDING_READS = 64;

  function automatic int cmd_width(input int addr_w, input int data_w, input int burst_w);
    return addr_w + data_w + data_w / 8 + burst_w + 2;
  endfunction

  localparam int DEF_CMD_WIDTH = cmd_width(DEF_ADDR_WIDTH, DEF_DATA_WIDTH, DEF_BURST_WIDTH);

  // Field order matches the concatenation used by the packer, MSB first.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH-1:0]   write_data;
    logic [DEF_DATA_WIDTH/8-1:0] byteenable;
    logic [DEF_BURST_WIDTH-1:0]  burstcount;
    logic                        sop;
    logic                        is_read;
  } t_avst_cmd;

endpackage

// File: rtl/avst_to_avmm_burst_master_if.sv
// AVMM slave bus plus AVST command/response channels; slave is the bridge side, master the environment.
interface avst_to_avmm_burst_master_if
  import avst_avmm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int BURST_WIDTH = DEF_BURST_WIDTH,
  localparam int CMD_WIDTH  = cmd_width(ADDR_WIDTH, DATA_WIDTH, BURST_WIDTH)
);

  logic [ADDR_WIDTH-1:0]   avmm_address;
  logic [DATA_WIDTH-1:0]   avmm_writedata;
  logic [DATA_WIDTH/8-1:0] avmm_byteenable;
  logic [BURST_WIDTH-1:0]  avmm_burstcount;
  logic                    avmm_write;
  logic                    avmm_read;
  logic                    avmm_waitrequest;
  logic [DATA_WIDTH-1:0]   avmm_readdata;
  logic                    avmm_readdatavalid;

  logic [CMD_WIDTH-1:0]    avst_avcmd_data;
  logic                    avst_avcmd_valid;
  logic                    avst_avcmd_ready;
  logic [DATA_WIDTH-1:0]   avst_rd_rsp_data;
  logic                    avst_rd_rsp_valid;
  logic                    avst_rd_rsp_ready;

  modport slave (
    input  avmm_address, avmm_writedata, avmm_byteenable, avmm_burstcount,
           avmm_write, avmm_read, avst_avcmd_ready, avst_rd_rsp_data, avst_rd_rsp_valid,
    output avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
           avst_avcmd_data, avst_avcmd_valid, avst_rd_rsp_ready
  );

  modport master (
    output avmm_address, avmm_writedata, avmm_byteenable, avmm_burstcount,
           avmm_write, avmm_read, avst_avcmd_ready, avst_rd_rsp_data, avst_rd_rsp_valid,
    input  avmm_waitrequest, avmm_readdata, avmm_readdatavalid,
           avst_avcmd_data, avst_avcmd_valid, avst_rd_rsp_ready
  );

endinterface

// File: rtl/avst_to_avmm_burst_master_skid.sv
// Two-entry in-order registered command buffer; head entry is presented directly on the output.
module avst_cmd_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = push_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = push_data;
        end else if (push) begin
          tail_d  = push_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // Upstream stalls pushes while full, but keep ordering sane if both arrive.
        if (pop) begin
          head_d = tail_q;
          if (push) begin
            tail_d = push_data;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign head_data = head_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

endmodule

// File: rtl/avst_to_avmm_burst_master.sv
// AVMM slave front end: packs read/write bursts into AVST commands and passes read responses back,
// bounding outstanding read beats with a credit counter.
module avst_to_avmm_burst_master
  import avst_avmm_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int AVMM_DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int AVMM_BURST_WIDTH  = DEF_BURST_WIDTH,
  parameter int MAX_PENDING_READS = DEF_MAX_PENDING_READS,
  localparam int BE_WIDTH   = AVMM_DATA_WIDTH / 8,
  localparam int CMD_WIDTH  = cmd_width(AVMM_ADDR_WIDTH, AVMM_DATA_WIDTH, AVMM_BURST_WIDTH),
  localparam int PEND_WIDTH = $clog2(MAX_PENDING_READS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avst_to_avmm_burst_master_if.slave bus,
  output logic [PEND_WIDTH-1:0] pending_reads,
  output logic                  err_unexpected_rsp
);

  logic [AVMM_BURST_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [AVMM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [AVMM_BURST_WIDTH-1:0] burst_q, burst_d;
  logic [PEND_WIDTH-1:0]       pending_q, pending_d;
  logic                        err_q, err_d;

  logic                        buf_full, buf_empty, push, pop;
  logic [CMD_WIDTH-1:0]        push_data, head_data;
  logic [31:0]                 credit_sum;
  logic                        credit_stall, burst_open, first_beat;
  logic                        waitrequest, wr_accept, rd_accept, rsp_beat;
  logic [AVMM_ADDR_WIDTH-1:0]  cmd_addr;
  logic [AVMM_BURST_WIDTH-1:0] cmd_burst;

  assign credit_sum   = 32'(pending_q) + 32'(bus.avmm_burstcount);
  assign credit_stall = bus.avmm_read && (credit_sum > 32'(MAX_PENDING_READS));
  assign burst_open   = (beat_cnt_q != '0);
  assign first_beat   = !burst_open;
  // Holding waitrequest high through reset comes straight from reset_n, not from a flop.
  assign waitrequest  = !reset_n || buf_full || credit_stall || (bus.avmm_read && burst_open);
  assign wr_accept    = bus.avmm_write && !waitrequest;
  assign rd_accept    = bus.avmm_read && !bus.avmm_write && !waitrequest;
  assign rsp_beat     = bus.avst_rd_rsp_valid && reset_n;
  assign cmd_addr     = first_beat ? bus.avmm_address : addr_q;
  assign cmd_burst    = first_beat ? bus.avmm_burstcount : burst_q;
  assign push         = wr_accept || rd_accept;
  assign pop          = !buf_empty && bus.avst_avcmd_ready;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    if (wr_accept) begin
      if (first_beat) begin
        addr_d  = bus.avmm_address;
        burst_d = bus.avmm_burstcount;
      end
      if (beat_cnt_q + AVMM_BURST_WIDTH'(1) == cmd_burst) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + AVMM_BURST_WIDTH'(1);
      end
    end
  end

  always_comb begin
    if (rd_accept) begin
      push_data = {bus.avmm_address, {AVMM_DATA_WIDTH{1'b0}}, {BE_WIDTH{1'b1}},
                   bus.avmm_burstcount, 1'b1, 1'b1};
    end else begin
      push_data = {cmd_addr, bus.avmm_writedata, bus.avmm_byteenable,
                   cmd_burst, first_beat, 1'b0};
    end
  end

  // A response with no outstanding credit is flagged and never lets the counter wrap below zero.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    if (rd_accept) begin
      pending_d = pending_d + PEND_WIDTH'(bus.avmm_burstcount);
    end
    if (rsp_beat) begin
      if (pending_q != '0) begin
        pending_d = pending_d - PEND_WIDTH'(1);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt_q <= '0;
      addr_q     <= '0;
      burst_q    <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  avst_cmd_skid_buffer #(
    .WIDTH (CMD_WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head_data),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign bus.avmm_waitrequest   = waitrequest;
  assign bus.avmm_readdata      = bus.avst_rd_rsp_data;
  assign bus.avmm_readdatavalid = rsp_beat;
  assign bus.avst_rd_rsp_ready  = reset_n;
  assign bus.avst_avcmd_valid   = !buf_empty;
  assign bus.avst_avcmd_data    = head_data;
  assign pending_reads          = pending_q;
  assign err_unexpected_rsp     = err_q;

endmodule

// File: tb/tb_avst_to_avmm_burst_master.sv
// Directed bench for the AVMM-to-AVST burst bridge with an 8-beat read credit limit.
module tb_avst_to_avmm_burst_master;
  import avst_avmm_pkg::*;

  logic       clk;
  logic       reset_n;
  logic [3:0] pending_reads;
  logic       err_unexpected_rsp;

  int tests_run;
  int tests_failed;

  t_avst_cmd cmd;
  t_avst_cmd mon_q[$];

  avst_to_avmm_burst_master_if bus ();

  avst_to_avmm_burst_master #(
    .MAX_PENDING_READS (8)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .bus                (bus),
    .pending_reads      (pending_reads),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cmd = bus.avst_avcmd_data;

  // Record every command handed downstream; inputs only change just after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (bus.avst_avcmd_valid && bus.avst_avcmd_ready) begin
      mon_q.push_back(cmd);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [47:0] addr,
                               input logic [2:0] burst, input logic [63:0] data_word);
    bus.avmm_write      = wr;
    bus.avmm_read       = rd;
    bus.avmm_address    = addr;
    bus.avmm_burstcount = burst;
    bus.avmm_writedata  = 512'(data_word);
    bus.avmm_byteenable = '1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int idx;
    logic w;
    logic wr;
    logic [63:0] be_ones;
    tests_run    = 0;
    tests_failed = 0;
    be_ones      = '1;
    reset_n      = 1'b0;
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    bus.avst_avcmd_ready  = 1'b1;
    bus.avst_rd_rsp_valid = 1'b1;
    bus.avst_rd_rsp_data  = 512'(64'h1234);

    repeat (2) tick();
    checkOutput("rst_waitrequest", 64'(bus.avmm_waitrequest), 64'd1);
    checkOutput("rst_avcmd_valid", 64'(bus.avst_avcmd_valid), 64'd0);
    checkOutput("rst_readdatavalid", 64'(bus.avmm_readdatavalid), 64'd0);
    checkOutput("rst_rsp_ready", 64'(bus.avst_rd_rsp_ready), 64'd0);
    checkOutput("rst_pending", 64'(pending_reads), 64'd0);
    checkOutput("rst_err", 64'(err_unexpected_rsp), 64'd0);

    reset_n = 1'b1;
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("idle_waitrequest", 64'(bus.avmm_waitrequest), 64'd0);
    checkOutput("idle_rsp_ready", 64'(bus.avst_rd_rsp_ready), 64'd1);

    // Single write, ready high
    applyStimulus(1'b1, 1'b0, 48'h100, 3'd1, 64'hCAFE_0001);
    #1;
    checkOutput("t1_accept", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    #1;
    checkOutput("t1_valid", 64'(bus.avst_avcmd_valid), 64'd1);
    checkOutput("t1_sop", 64'(cmd.sop), 64'd1);
    checkOutput("t1_is_read", 64'(cmd.is_read), 64'd0);
    checkOutput("t1_addr", 64'(cmd.addr), 64'h100);
    checkOutput("t1_burst", 64'(cmd.burstcount), 64'd1);
    checkOutput("t1_be", cmd.byteenable, be_ones);
    checkOutput("t1_data", cmd.write_data[63:0], 64'hCAFE_0001);
    tick();
    checkOutput("t1_drained", 64'(bus.avst_avcmd_valid), 64'd0);

    // Four-beat write burst with ready low in cycles 2 and 3
    mon_q.delete();
    idx = 0;
    for (int cyc = 1; cyc < 20 && idx < 4; cyc++) begin
      bus.avst_avcmd_ready = !(cyc == 2 || cyc == 3);
      wr = (idx < 4);
      applyStimulus(wr, 1'b0, (idx == 0) ? 48'h40 : 48'hFFF, 3'd4, 64'hD000 + 64'(idx));
      #1;
      w = bus.avmm_waitrequest;
      if (cyc == 2) checkOutput("t2_wait_one_buffered", 64'(w), 64'd0);
      if (cyc == 3) checkOutput("t2_wait_full", 64'(w), 64'd1);
      tick();
      if (wr && !w) idx++;
    end
    checkOutput("t2_beats_accepted", 64'(idx), 64'd4);
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    bus.avst_avcmd_ready = 1'b1;
    repeat (4) tick();
    checkOutput("t2_cmd_count", 64'(mon_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < mon_q.size(); i++) begin
      checkOutput($sformatf("t2_addr%0d", i), 64'(mon_q[i].addr), 64'h40);
      checkOutput($sformatf("t2_burst%0d", i), 64'(mon_q[i].burstcount), 64'd4);
      checkOutput($sformatf("t2_sop%0d", i), 64'(mon_q[i].sop), (i == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t2_data%0d", i), mon_q[i].write_data[63:0], 64'hD000 + 64'(i));
    end

    // Read credit limit of 8 beats
    mon_q.delete();
    applyStimulus(1'b0, 1'b1, 48'h200, 3'd4, 64'h0);
    #1;
    checkOutput("t3_rd1_accept", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    checkOutput("t3_pending4", 64'(pending_reads), 64'd4);
    applyStimulus(1'b0, 1'b1, 48'h240, 3'd4, 64'h0);
    #1;
    checkOutput("t3_rd2_accept", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    checkOutput("t3_pending8", 64'(pending_reads), 64'd8);
    applyStimulus(1'b0, 1'b1, 48'h280, 3'd1, 64'h0);
    #1;
    checkOutput("t3_rd3_stall", 64'(bus.avmm_waitrequest), 64'd1);
    tick();
    checkOutput("t3_stall_pending", 64'(pending_reads), 64'd8);
    bus.avst_rd_rsp_valid = 1'b1;
    bus.avst_rd_rsp_data  = 512'(64'hBEEF_0001);
    #1;
    checkOutput("t3_rdv", 64'(bus.avmm_readdatavalid), 64'd1);
    checkOutput("t3_rdata", bus.avmm_readdata[63:0], 64'hBEEF_0001);
    checkOutput("t3_still_stall", 64'(bus.avmm_waitrequest), 64'd1);
    tick();
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("t3_pending7", 64'(pending_reads), 64'd7);
    checkOutput("t3_rd3_release", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    #1;
    checkOutput("t3_pending8_again", 64'(pending_reads), 64'd8);
    repeat (2) tick();
    checkOutput("t3_cmd_count", 64'(mon_q.size()), 64'd3);
    if (mon_q.size() == 3) begin
      checkOutput("t3_c0_burst", 64'(mon_q[0].burstcount), 64'd4);
      checkOutput("t3_c2_addr", 64'(mon_q[2].addr), 64'h280);
      checkOutput("t3_c2_burst", 64'(mon_q[2].burstcount), 64'd1);
      checkOutput("t3_c2_is_read", 64'(mon_q[2].is_read), 64'd1);
      checkOutput("t3_c2_sop", 64'(mon_q[2].sop), 64'd1);
      checkOutput("t3_c2_be", mon_q[2].byteenable, be_ones);
      checkOutput("t3_c2_wdata", mon_q[2].write_data[63:0], 64'd0);
    end

    // Read accept coinciding with a response beat
    bus.avst_rd_rsp_valid = 1'b1;
    repeat (5) tick();
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("t4_pending3", 64'(pending_reads), 64'd3);
    applyStimulus(1'b0, 1'b1, 48'h400, 3'd2, 64'h0);
    bus.avst_rd_rsp_valid = 1'b1;
    #1;
    checkOutput("t4_accept", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("t4_pending4", 64'(pending_reads), 64'd4);
    bus.avst_rd_rsp_valid = 1'b1;
    repeat (4) tick();
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("t4_pending0", 64'(pending_reads), 64'd0);
    checkOutput("t4_no_err", 64'(err_unexpected_rsp), 64'd0);

    // Unexpected response with nothing outstanding
    bus.avst_rd_rsp_valid = 1'b1;
    bus.avst_rd_rsp_data  = 512'(64'h5A5A_5A5A);
    #1;
    checkOutput("t5_rdv", 64'(bus.avmm_readdatavalid), 64'd1);
    checkOutput("t5_rdata", bus.avmm_readdata[63:0], 64'h5A5A_5A5A);
    tick();
    bus.avst_rd_rsp_valid = 1'b0;
    #1;
    checkOutput("t5_err_set", 64'(err_unexpected_rsp), 64'd1);
    checkOutput("t5_pending_hold", 64'(pending_reads), 64'd0);
    tick();
    checkOutput("t5_err_sticky", 64'(err_unexpected_rsp), 64'd1);

    // Reset dropped after two beats of a four-beat write
    applyStimulus(1'b1, 1'b0, 48'h300, 3'd4, 64'h30);
    tick();
    applyStimulus(1'b1, 1'b0, 48'h300, 3'd4, 64'h31);
    tick();
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 64'(bus.avst_avcmd_valid), 64'd0);
    checkOutput("t6_rst_wait", 64'(bus.avmm_waitrequest), 64'd1);
    checkOutput("t6_rst_err", 64'(err_unexpected_rsp), 64'd0);
    tick();
    reset_n = 1'b1;
    #1;
    mon_q.delete();
    applyStimulus(1'b1, 1'b0, 48'h500, 3'd2, 64'h50);
    #1;
    checkOutput("t6_fresh_accept", 64'(bus.avmm_waitrequest), 64'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 48'h500, 3'd2, 64'h51);
    #1;
    checkOutput("t6_fresh_valid", 64'(bus.avst_avcmd_valid), 64'd1);
    checkOutput("t6_fresh_sop", 64'(cmd.sop), 64'd1);
    checkOutput("t6_fresh_addr", 64'(cmd.addr), 64'h500);
    checkOutput("t6_fresh_burst", 64'(cmd.burstcount), 64'd2);
    tick();
    applyStimulus(1'b0, 1'b0, 48'h0, 3'd1, 64'h0);
    #1;
    checkOutput("t6_beat2_sop", 64'(cmd.sop), 64'd0);
    repeat (2) tick();
    checkOutput("t6_cmd_count", 64'(mon_q.size()), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
